mii_rx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 34 +++
 rtl/mii_rx_framer_if.sv | 29 ++
 rtl/crc32_d8.sv | 23 ++
 rtl/mii_rx_framer.sv | 214 +++++++++++++++++++++
 tb/tb_mii_rx_framer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, rx framer state encoding and status bit indices.
// Also carries the bit-reversal helper used by the CRC logic.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    localparam int unsigned ERR_W       = 5;
    localparam int unsigned ERR_CRC     = 0;
    localparam int unsigned ERR_RUNT    = 1;
    localparam int unsigned ERR_GIANT   = 2;
    localparam int unsigned ERR_RXER    = 3;
    localparam int unsigned ERR_DRIBBLE = 4;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_PREAMBLE = 2'd1,
        RX_DATA     = 2'd2,
        RX_DROP     = 2'd3
    } rx_state_e;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mii_rx_framer_if.sv
// PHY-side MII receive pins plus the framed byte stream and per-frame status.
// slave = framer side, master = PHY/consumer side.
interface mii_rx_framer_if #(
    parameter int unsigned LEN_W = 11
);
    logic                        mii_rxdv;
    logic [3:0]                  mii_rxd;
    logic                        mii_rxer;
    logic                        out_valid;
    logic [7:0]                  out_data;
    logic                        out_sof;
    logic                        out_eof;
    logic                        frame_done;
    logic                        frame_ok;
    logic [LEN_W-1:0]            frame_len;
    logic [eth_pkg::ERR_W-1:0]   err_flags;

    modport master (
        output mii_rxdv, mii_rxd, mii_rxer,
        input  out_valid, out_data, out_sof, out_eof,
        input  frame_done, frame_ok, frame_len, err_flags
    );

    modport slave (
        input  mii_rxdv, mii_rxd, mii_rxer,
        output out_valid, out_data, out_sof, out_eof,
        output frame_done, frame_ok, frame_len, err_flags
    );
endinterface

// File: rtl/crc32_d8.sv
// Combinational reflected CRC32 update by one byte (LSB first); shared with the tx FCS path.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

    logic [31:0] w_c;

    always_comb begin
        w_c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ POLY_R) : (w_c >> 1);
        end
    end

    assign crc_out = w_c;

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes behind a one-byte
// hold register, and reports CRC/length/error status at each frame end.
module mii_rx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME_BYTES = 64,
    parameter int unsigned MAX_FRAME_BYTES = 1518,
    parameter int unsigned LEN_W           = 11
) (
    input  logic           clk,
    input  logic           reset_n,
    mii_rx_framer_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_BYTES);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_BYTES);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME_BYTES + 1);

    logic             r_rxdv, r_rxer;
    logic [3:0]       r_rxd;
    rx_state_e        r_state, w_state_next;

    logic             r_phase, w_phase;
    logic [3:0]       r_lo, w_lo;
    logic [7:0]       r_hold, w_hold;
    logic             r_have_hold, w_have_hold;
    logic [LEN_W-1:0] r_len, w_len;
    logic [31:0]      r_crc, w_crc;
    logic             r_rxer_seen, w_rxer_seen;

    logic             r_out_valid, w_out_valid;
    logic [7:0]       r_out_data, w_out_data;
    logic             r_out_sof, w_out_sof;
    logic             r_out_eof, w_out_eof;
    logic             r_frame_done, w_frame_done;
    logic             r_frame_ok, w_frame_ok;
    logic [LEN_W-1:0] r_frame_len, w_frame_len;
    logic [ERR_W-1:0] r_err_flags, w_err_flags;
    logic [ERR_W-1:0] w_flags;

    logic [7:0]       w_byte;
    logic [31:0]      w_crc_byte;
    logic             w_in_data, w_byte_done, w_giant, w_end, w_start;

    // Pins are sampled without reset so DROP sees the live rxdv as soon as reset lifts.
    always_ff @(posedge clk) begin
        r_rxdv <= bus.mii_rxdv;
        r_rxd  <= bus.mii_rxd;
        r_rxer <= bus.mii_rxer;
    end

    assign w_byte      = {r_rxd, r_lo};
    assign w_in_data   = (r_state == RX_DATA);
    assign w_byte_done = w_in_data && r_rxdv && r_phase;
    assign w_giant     = w_byte_done && (r_len == LEN_MAX);
    assign w_end       = w_in_data && !r_rxdv;
    assign w_start     = (r_state == RX_PREAMBLE) && r_rxdv && !r_rxer && (r_rxd == SFD_NIB);

    crc32_d8 u_crc32_d8 (
        .crc_in  (r_crc),
        .data    (w_byte),
        .crc_out (w_crc_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= RX_DROP;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (r_rxdv) w_state_next = (r_rxd == PREAMBLE_NIB) ? RX_PREAMBLE : RX_DROP;
            end
            RX_PREAMBLE: begin
                if (!r_rxdv)                  w_state_next = RX_IDLE;
                else if (r_rxer)              w_state_next = RX_DROP;
                else if (r_rxd == SFD_NIB)    w_state_next = RX_DATA;
                else if (r_rxd != PREAMBLE_NIB) w_state_next = RX_DROP;
            end
            RX_DATA: begin
                if (!r_rxdv)      w_state_next = RX_IDLE;
                else if (w_giant) w_state_next = RX_DROP;
            end
            default: begin
                if (!r_rxdv) w_state_next = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        w_phase      = r_phase;
        w_lo         = r_lo;
        w_hold       = r_hold;
        w_have_hold  = r_have_hold;
        w_len        = r_len;
        w_crc        = r_crc;
        w_rxer_seen  = r_rxer_seen;
        w_out_valid  = 1'b0;
        w_out_data   = r_out_data;
        w_out_sof    = 1'b0;
        w_out_eof    = 1'b0;
        w_frame_done = 1'b0;
        w_frame_ok   = r_frame_ok;
        w_frame_len  = r_frame_len;
        w_err_flags  = r_err_flags;
        w_flags      = '0;

        if (w_start) begin
            w_phase     = 1'b0;
            w_have_hold = 1'b0;
            w_len       = '0;
            w_crc       = CRC32_INIT;
            w_rxer_seen = 1'b0;
        end

        if (w_in_data && r_rxdv) begin
            if (r_rxer) w_rxer_seen = 1'b1;
            if (!r_phase) begin
                w_lo    = r_rxd;
                w_phase = 1'b1;
            end else begin
                w_phase = 1'b0;
                w_crc   = w_crc_byte;
                // Each completed byte pushes the previously held one downstream.
                if (r_have_hold) begin
                    w_out_valid = 1'b1;
                    w_out_data  = r_hold;
                    w_out_sof   = (r_len == LEN_ONE);
                end
                w_hold      = w_byte;
                w_have_hold = 1'b1;
                w_len       = (r_len == LEN_SAT) ? r_len : r_len + LEN_ONE;
                if (w_giant) begin
                    w_out_eof          = 1'b1;
                    w_frame_done       = 1'b1;
                    w_have_hold        = 1'b0;
                    w_flags[ERR_GIANT] = 1'b1;
                    w_flags[ERR_RXER]  = r_rxer_seen || r_rxer;
                    w_err_flags        = w_flags;
                    w_frame_ok         = 1'b0;
                    w_frame_len        = LEN_MAX;
                end
            end
        end

        if (w_end) begin
            w_frame_done = 1'b1;
            w_have_hold  = 1'b0;
            if (r_have_hold) begin
                w_out_valid = 1'b1;
                w_out_data  = r_hold;
                w_out_sof   = (r_len == LEN_ONE);
                w_out_eof   = 1'b1;
            end
            // The register holds the reflected residue; compare in transmitted bit order.
            w_flags[ERR_CRC]     = (reflect32(r_crc) != CRC32_RESIDUE);
            w_flags[ERR_RUNT]    = (r_len < LEN_MIN);
            w_flags[ERR_RXER]    = r_rxer_seen;
            w_flags[ERR_DRIBBLE] = r_phase;
            w_err_flags          = w_flags;
            w_frame_ok           = (w_flags == '0);
            w_frame_len          = r_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase      <= 1'b0;
            r_lo         <= '0;
            r_hold       <= '0;
            r_have_hold  <= 1'b0;
            r_len        <= '0;
            r_crc        <= CRC32_INIT;
            r_rxer_seen  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_len  <= '0;
            r_err_flags  <= '0;
        end else begin
            r_phase      <= w_phase;
            r_lo         <= w_lo;
            r_hold       <= w_hold;
            r_have_hold  <= w_have_hold;
            r_len        <= w_len;
            r_crc        <= w_crc;
            r_rxer_seen  <= w_rxer_seen;
            r_out_valid  <= w_out_valid;
            r_out_data   <= w_out_data;
            r_out_sof    <= w_out_sof;
            r_out_eof    <= w_out_eof;
            r_frame_done <= w_frame_done;
            r_frame_ok   <= w_frame_ok;
            r_frame_len  <= w_frame_len;
            r_err_flags  <= w_err_flags;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_sof    = r_out_sof;
    assign bus.out_eof    = r_out_eof;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_ok   = r_frame_ok;
    assign bus.frame_len  = r_frame_len;
    assign bus.err_flags  = r_err_flags;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Bench for mii_rx_framer: nibble-level frame driver, byte/status monitor and a
// frame-level reference model (FCS comparison, length rules, error conditions).
module tb_mii_rx_framer;
    import eth_pkg::*;

    localparam int MIN_B = 64;
    localparam int MAX_B = 1518;
    localparam int unsigned LEN_W = 11;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int               first;
        int               count;
        bit               sof_ok;
        bit               eof_ok;
        logic             ok;
        logic [LEN_W-1:0] len;
        logic [4:0]       flags;
    } rec_t;

    typedef struct {
        int               nbytes;
        logic             ok;
        logic [LEN_W-1:0] len;
        logic [4:0]       flags;
        logic [4:0]       mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mii_rx_framer_if #(.LEN_W(LEN_W)) bus ();

    mii_rx_framer #(
        .MIN_FRAME_BYTES (MIN_B),
        .MAX_FRAME_BYTES (MAX_B),
        .LEN_W           (LEN_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Monitor: collects every delivered byte and one record per frame_done.
    logic [7:0] rx_all[$];
    rec_t       res_q[$];
    rec_t       mon_rec;
    int         cur_first = 0;
    int         cur_count = 0;
    bit         cur_sof_ok = 1'b1;
    bit         cur_eof_ok = 1'b1;

    always @(negedge clk) begin
        if (!reset_n) begin
            cur_first  = rx_all.size();
            cur_count  = 0;
            cur_sof_ok = 1'b1;
            cur_eof_ok = 1'b1;
        end else begin
            if (bus.out_valid === 1'b1) begin
                if (bus.out_sof !== (cur_count == 0)) cur_sof_ok = 1'b0;
                if (bus.out_eof !== bus.frame_done) cur_eof_ok = 1'b0;
                rx_all.push_back(bus.out_data);
                cur_count++;
            end
            if (bus.frame_done === 1'b1) begin
                if (cur_count > 0 && !(bus.out_valid === 1'b1 && bus.out_eof === 1'b1)) cur_eof_ok = 1'b0;
                mon_rec.first  = cur_first;
                mon_rec.count  = cur_count;
                mon_rec.sof_ok = cur_sof_ok;
                mon_rec.eof_ok = cur_eof_ok;
                mon_rec.ok     = bus.frame_ok;
                mon_rec.len    = bus.frame_len;
                mon_rec.flags  = bus.err_flags;
                res_q.push_back(mon_rec);
                cur_first  = rx_all.size();
                cur_count  = 0;
                cur_sof_ok = 1'b1;
                cur_eof_ok = 1'b1;
            end
        end
    end

    // Ethernet FCS: complemented reflected CRC32 over the preceding bytes.
    function automatic logic [31:0] fcs_of(input bq_t q, input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(input int plen, input bit incr);
        bq_t q;
        logic [31:0] f;
        for (int i = 0; i < plen; i++) q.push_back(incr ? 8'(i) : 8'($urandom));
        f = fcs_of(q, plen);
        q.push_back(f[7:0]);
        q.push_back(f[15:8]);
        q.push_back(f[23:16]);
        q.push_back(f[31:24]);
        return q;
    endfunction

    function automatic bit fcs_good(input bq_t q);
        int n = q.size();
        if (n < 4) return 1'b0;
        return {q[n-1], q[n-2], q[n-3], q[n-4]} == fcs_of(q, n - 4);
    endfunction

    function automatic exp_t model(input bq_t q, input bit had_rxer, input bit dribble);
        exp_t e;
        int n = q.size();
        if (n > MAX_B) begin
            e.nbytes = MAX_B;
            e.flags  = 5'b00100;
            e.mask   = 5'b00100;
        end else begin
            e.nbytes = n;
            e.flags  = {dribble, had_rxer, 1'b0, (n < MIN_B), !fcs_good(q)};
            e.mask   = 5'b11111;
        end
        e.len = LEN_W'(e.nbytes);
        e.ok  = (e.flags == 5'b00000);
        return e;
    endfunction

    function automatic int byte_errs(input int first, input bq_t q, input int qoff, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (first + i >= rx_all.size()) e++;
            else if (rx_all[first+i] !== q[qoff+i]) e++;
        end
        return e;
    endfunction

    task automatic drive_nib(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk);
        bus.mii_rxdv = dv;
        bus.mii_rxd  = d;
        bus.mii_rxer = er;
    endtask

    task automatic send_frame(input bq_t q, input int pre_len, input int rxer_nib, input bit extra);
        for (int i = 0; i < pre_len; i++) drive_nib(1'b1, PREAMBLE_NIB, 1'b0);
        drive_nib(1'b1, SFD_NIB, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            drive_nib(1'b1, q[i][3:0], rxer_nib == 2 * i);
            drive_nib(1'b1, q[i][7:4], rxer_nib == 2 * i + 1);
        end
        if (extra) drive_nib(1'b1, 4'($urandom), 1'b0);
        drive_nib(1'b0, 4'h0, 1'b0);
    endtask

    task automatic wait_rec(input int want, output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (res_q.size() >= want) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.mii_rxdv = 1'b0;
        bus.mii_rxd  = 4'h0;
        bus.mii_rxer = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sof, bus.out_eof, bus.frame_done, bus.frame_ok,
             bus.frame_len, bus.err_flags, bus.out_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {bus.out_valid, bus.out_sof, bus.out_eof,
                     bus.frame_done, bus.frame_ok, bus.frame_len, bus.err_flags, bus.out_data});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (res_q.size() !== 0 || rx_all.size() !== 0) begin
            failures++;
            $display("FAIL reset_idle_activity got=%0d exp=0", res_q.size() + rx_all.size());
        end
    endtask

    // Single frame through the driver, then every field of its record against the model.
    task automatic test_frame(input string name, input bq_t q, input int rxer_nib, input bit extra);
        exp_t e = model(q, rxer_nib >= 0, extra);
        int   base = res_q.size();
        bit   got;
        int   nbad;
        rec_t r;
        send_frame(q, 15, rxer_nib, extra);
        wait_rec(base + 1, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_done got=timeout exp=frame_done", name);
            return;
        end
        r = res_q[base];
        checks++;
        if (r.count !== e.nbytes) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, r.count, e.nbytes); end
        nbad = byte_errs(r.first, q, 0, e.nbytes);
        checks++;
        if (nbad !== 0) begin failures++; $display("FAIL %s_bytes got=%0d_bad exp=0_bad", name, nbad); end
        checks++;
        if ({r.sof_ok, r.eof_ok} !== 2'b11) begin failures++; $display("FAIL %s_sof_eof got=%b exp=11", name, {r.sof_ok, r.eof_ok}); end
        checks++;
        if (r.ok !== e.ok) begin failures++; $display("FAIL %s_frame_ok got=%b exp=%b", name, r.ok, e.ok); end
        checks++;
        if (r.len !== e.len) begin failures++; $display("FAIL %s_len got=%0d exp=%0d", name, r.len, e.len); end
        checks++;
        if ((r.flags & e.mask) !== e.flags) begin failures++; $display("FAIL %s_flags got=%b exp=%b", name, r.flags, e.flags); end
    endtask

    task automatic test_good_frame();
        test_frame("good", make_frame(60, 1'b1), -1, 1'b0);
    endtask

    task automatic test_crc_error();
        bq_t q = make_frame(60, 1'b1);
        q[10] = q[10] ^ 8'h01;
        test_frame("crc", q, -1, 1'b0);
    endtask

    task automatic test_rxer_dribble();
        test_frame("rxer", make_frame(60, 1'b1), 40, 1'b0);
        test_frame("dribble", make_frame(60, 1'b0), -1, 1'b1);
    endtask

    task automatic test_runt_zero();
        bq_t empty;
        test_frame("runt", make_frame(36, 1'b0), -1, 1'b0);
        test_frame("zero", empty, -1, 1'b0);
    endtask

    // Giant frame followed after a single idle cycle by a good frame.
    task automatic test_giant();
        bq_t  g = make_frame(1596, 1'b0);
        bq_t  q = make_frame(60, 1'b0);
        exp_t eg = model(g, 1'b0, 1'b0);
        exp_t eq = model(q, 1'b0, 1'b0);
        int   base = res_q.size();
        bit   got;
        int   nbad;
        rec_t r;
        send_frame(g, 15, -1, 1'b0);
        send_frame(q, 15, -1, 1'b0);
        wait_rec(base + 2, got);
        checks++;
        if (!got || res_q.size() !== base + 2) begin
            failures++;
            $display("FAIL giant_records got=%0d exp=2", res_q.size() - base);
            return;
        end
        r = res_q[base];
        nbad = byte_errs(r.first, g, 0, eg.nbytes);
        checks++;
        if (r.count !== eg.nbytes || nbad !== 0) begin
            failures++;
            $display("FAIL giant_bytes got=%0d/%0d_bad exp=%0d/0_bad", r.count, nbad, eg.nbytes);
        end
        checks++;
        if ({r.sof_ok, r.eof_ok, r.ok, r.len, r.flags[2]} !== {2'b11, 1'b0, eg.len, 1'b1}) begin
            failures++;
            $display("FAIL giant_status got=%b_%b_%0d_%b exp=11_0_%0d_flag2", {r.sof_ok, r.eof_ok}, r.ok, r.len, r.flags, eg.len);
        end
        r = res_q[base+1];
        nbad = byte_errs(r.first, q, 0, eq.nbytes);
        checks++;
        if (r.count !== eq.nbytes || nbad !== 0 || {r.sof_ok, r.eof_ok} !== 2'b11) begin
            failures++;
            $display("FAIL after_giant_bytes got=%0d/%0d_bad exp=%0d/0_bad", r.count, nbad, eq.nbytes);
        end
        checks++;
        if ({r.ok, r.len, r.flags} !== {1'b1, eq.len, 5'b00000}) begin
            failures++;
            $display("FAIL after_giant_status got=%b_%0d_%b exp=1_%0d_00000", r.ok, r.len, r.flags, eq.len);
        end
    endtask

    // Randomized lengths, preambles and single-bit corruption, one idle cycle apart.
    task automatic test_back_to_back();
        localparam int NF = 6;
        bq_t  flat;
        bq_t  q;
        exp_t ex[NF];
        int   off[NF];
        int   base = res_q.size();
        bit   got;
        int   nbad;
        rec_t r;
        for (int f = 0; f < NF; f++) begin
            q = make_frame(int'($urandom_range(20, 120)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                int k = int'($urandom_range(0, q.size() - 1));
                q[k] = q[k] ^ 8'(1 << $urandom_range(0, 7));
            end
            ex[f]  = model(q, 1'b0, 1'b0);
            off[f] = flat.size();
            foreach (q[i]) flat.push_back(q[i]);
            send_frame(q, int'($urandom_range(1, 15)), -1, 1'b0);
        end
        wait_rec(base + NF, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL b2b_records got=%0d exp=%0d", res_q.size() - base, NF);
            return;
        end
        for (int f = 0; f < NF; f++) begin
            r = res_q[base+f];
            nbad = byte_errs(r.first, flat, off[f], ex[f].nbytes);
            checks++;
            if (r.count !== ex[f].nbytes || nbad !== 0 || {r.sof_ok, r.eof_ok} !== 2'b11) begin
                failures++;
                $display("FAIL b2b%0d_bytes got=%0d/%0d_bad exp=%0d/0_bad", f, r.count, nbad, ex[f].nbytes);
            end
            checks++;
            if ({r.ok, r.len, r.flags} !== {ex[f].ok, ex[f].len, ex[f].flags}) begin
                failures++;
                $display("FAIL b2b%0d_status got=%b_%0d_%b exp=%b_%0d_%b", f, r.ok, r.len, r.flags,
                         ex[f].ok, ex[f].len, ex[f].flags);
            end
        end
    endtask

    // Reset pulse in the middle of a frame; the remainder of that frame must be dropped.
    task automatic test_reset_mid();
        localparam int RS = 16 + 2 * 30;
        bq_t        q = make_frame(60, 1'b0);
        logic [3:0] nib[$];
        int         base = res_q.size();
        int         rx_mark = 0;
        for (int i = 0; i < 15; i++) nib.push_back(PREAMBLE_NIB);
        nib.push_back(SFD_NIB);
        foreach (q[i]) begin
            nib.push_back(q[i][3:0]);
            nib.push_back(q[i][7:4]);
        end
        for (int j = 0; j < nib.size(); j++) begin
            @(negedge clk);
            if (j > RS && j <= RS + 3) begin
                checks++;
                if ({bus.out_valid, bus.out_sof, bus.out_eof, bus.frame_done, bus.frame_ok,
                     bus.frame_len, bus.err_flags, bus.out_data} !== '0) begin
                    failures++;
                    $display("FAIL reset_mid_outputs got=%0h exp=0", {bus.out_valid, bus.out_sof, bus.out_eof,
                             bus.frame_done, bus.frame_ok, bus.frame_len, bus.err_flags, bus.out_data});
                end
            end
            if (j == RS + 3) rx_mark = rx_all.size();
            reset_n      = !(j >= RS && j < RS + 3);
            bus.mii_rxdv = 1'b1;
            bus.mii_rxd  = nib[j];
            bus.mii_rxer = 1'b0;
        end
        drive_nib(1'b0, 4'h0, 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if (rx_all.size() !== rx_mark || res_q.size() !== base) begin
            failures++;
            $display("FAIL reset_mid_dropped got=%0d_bytes_%0d_frames exp=0_0",
                     rx_all.size() - rx_mark, res_q.size() - base);
        end
        test_frame("post_reset", make_frame(60, 1'b0), -1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_rxer_dribble();
        test_runt_zero();
        test_giant();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
